// File: rtl/pending_priority_encoder.sv
// pending_priority_encoder: latches request pulses and offers the top unmasked pending index over valid/ready
module pending_priority_encoder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic [WIDTH-1:0] mask,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [WIDTH-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t           state_q;
  logic             valid_q, ovf_q, ovf_d, hs;
  logic [IDX_W-1:0] idx_q, pick;
  logic [WIDTH-1:0] pending_q, pending_d, clr, cand;
  assign hs        = valid_q & out_ready;
  assign clr       = hs ? (WIDTH'(1) << idx_q) : '0;
  assign pending_d = (pending_q & ~clr) | req_in;
  assign cand      = pending_d & mask;
  assign ovf_d     = (|(req_in & pending_q & ~clr)) | (ovf_q & ~ovf_clr);
  // the last matching bit in scan order wins, so scan direction sets priority
  always_comb begin
    pick = '0;
    for (int i = 0; i < WIDTH; i++)
      if (cand[MSB_FIRST != 0 ? i : WIDTH-1-i]) pick = IDX_W'(MSB_FIRST != 0 ? i : WIDTH-1-i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      if (state_q == IDLE || hs) begin
        state_q <= |cand ? OFFER : IDLE;
        valid_q <= |cand;
        if (|cand) idx_q <= pick;
      end
    end
  end
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_pending_priority_encoder.sv
// tb_pending_priority_encoder: directed scoreboard bench for both priority directions
module tb_pending_priority_encoder;
  logic       clk = 1'b0, rst = 1'b0, rdy = 1'b0, oclr = 1'b0;
  logic [7:0] req = '0, msk = 8'hFF;
  logic       va, vb, oa, ob;
  logic [2:0] ia, ib;
  logic [7:0] pa, pb;
  int checks = 0, errors = 0;
  typedef struct {string tag; bit b; logic v; logic [2:0] idx; logic [7:0] pend; logic ov;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  pending_priority_encoder #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .req_in(req), .mask(msk), .out_ready(rdy),
    .out_valid(va), .out_idx(ia), .pending(pa), .ovf(oa), .ovf_clr(oclr));
  pending_priority_encoder #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .req_in(req), .mask(msk), .out_ready(rdy),
    .out_valid(vb), .out_idx(ib), .pending(pb), .ovf(ob), .ovf_clr(oclr));
  task automatic chk(string tag, string f, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, f, obs, exp);
    end
  endtask
  task automatic step(string tag, bit r, logic [7:0] rq, logic [7:0] m, bit rd, bit oc,
                      bit b, logic v, logic [2:0] idx, logic [7:0] pend, logic ov);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; msk = m; rdy = rd; oclr = oc;
    q.push_back('{tag, b, v, idx, pend, ov});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk(e.tag, "valid", {7'd0, e.b ? vb : va}, {7'd0, e.v});
    if (e.v) chk(e.tag, "idx", {5'd0, e.b ? ib : ia}, {5'd0, e.idx});
    chk(e.tag, "pending", e.b ? pb : pa, e.pend);
    chk(e.tag, "ovf", {7'd0, e.b ? ob : oa}, {7'd0, e.ov});
  endtask
  initial begin
    step("reset",     1, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0);
    step("seq29_5",   0, 8'h29, 8'hFF, 1, 0, 0, 1, 5, 8'h29, 0);
    step("seq29_3",   0, 8'h00, 8'hFF, 1, 0, 0, 1, 3, 8'h09, 0);
    step("seq29_0",   0, 8'h00, 8'hFF, 1, 0, 0, 1, 0, 8'h01, 0);
    step("seq29_end", 0, 8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0);
    step("hold_2",    0, 8'h04, 8'hFF, 0, 0, 0, 1, 2, 8'h04, 0);
    step("hold_hi",   0, 8'h80, 8'hFF, 0, 0, 0, 1, 2, 8'h84, 0);
    step("ack_to_7",  0, 8'h00, 8'hFF, 1, 0, 0, 1, 7, 8'h80, 0);
    step("ack_7",     0, 8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0);
    step("masked",    0, 8'hF0, 8'h0F, 1, 0, 0, 0, 0, 8'hF0, 0);
    step("mask_hold", 0, 8'h00, 8'h0F, 1, 0, 0, 0, 0, 8'hF0, 0);
    step("unmask",    0, 8'h00, 8'hFF, 0, 0, 0, 1, 7, 8'hF0, 0);
    step("drain_6",   0, 8'h00, 8'hFF, 1, 0, 0, 1, 6, 8'h70, 0);
    step("drain_5",   0, 8'h00, 8'hFF, 1, 0, 0, 1, 5, 8'h30, 0);
    step("drain_4",   0, 8'h00, 8'hFF, 1, 0, 0, 1, 4, 8'h10, 0);
    step("ovf_set",   0, 8'h10, 8'hFF, 0, 0, 0, 1, 4, 8'h10, 1);
    step("ovf_clr",   0, 8'h00, 8'hFF, 0, 1, 0, 1, 4, 8'h10, 0);
    step("set_wins",  0, 8'h10, 8'hFF, 1, 0, 0, 1, 4, 8'h10, 0);
    step("ovf_race",  0, 8'h10, 8'hFF, 0, 1, 0, 1, 4, 8'h10, 1);
    step("ovf_clr2",  0, 8'h00, 8'hFF, 0, 1, 0, 1, 4, 8'h10, 0);
    step("drain_end", 0, 8'h00, 8'hFF, 1, 0, 0, 0, 0, 8'h00, 0);
    step("lsb_reset", 1, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 0);
    step("lsb_0",     0, 8'h29, 8'hFF, 1, 0, 1, 1, 0, 8'h29, 0);
    step("lsb_3",     0, 8'h00, 8'hFF, 1, 0, 1, 1, 3, 8'h28, 0);
    step("rst_mid",   1, 8'h01, 8'hFF, 1, 0, 1, 0, 0, 8'h00, 0);
    step("post_rst",  0, 8'h00, 8'hFF, 1, 0, 1, 0, 0, 8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
